// File: rtl/interp_pass_sequencer_pkg.sv
// Shared geometry, types and helpers for the interpolation pass sequencer.
package interp_pass_sequencer_pkg;

  localparam int WIDTH     = 16;
  localparam int HEIGHT    = 16;
  localparam int DATA_W    = 8;
  localparam int PAD_LEAD  = 7;
  localparam int PAD_TRAIL = 6;
  localparam int CAP_OFS   = PAD_LEAD + PAD_TRAIL;
  localparam int OUT_LSB   = 6;
  localparam int OUT_W     = 14;
  localparam int ADDR_W    = $clog2(WIDTH * HEIGHT);

  localparam int MAX_DIM   = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  // Row-mode line length; column mode swaps WIDTH for HEIGHT.
  localparam int LL        = PAD_LEAD + WIDTH + PAD_TRAIL;
  localparam int LL_MAX    = PAD_LEAD + MAX_DIM + PAD_TRAIL;
  localparam int K_W       = $clog2(LL_MAX);
  // Line counter must be able to hold NL itself (the "no reads left" marker).
  localparam int L_W       = $clog2(MAX_DIM + 1);

  typedef enum logic {
    ROW = 1'b0,
    COL = 1'b1
  } pass_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Sample index within a line for feed index k, with edge replication.
  function automatic logic [K_W-1:0] src_index(input logic [K_W-1:0] k,
                                               input logic [K_W-1:0] ns);
    if (k < K_W'(PAD_LEAD))
      return '0;
    else if (k < K_W'(PAD_LEAD) + ns)
      return k - K_W'(PAD_LEAD);
    else
      return ns - K_W'(1);
  endfunction

endpackage

// File: rtl/interp_pass_sequencer_addr_gen.sv
// Maps (mode, line, sample) to a linear pixel address r*WIDTH+c.
module interp_pass_sequencer_addr_gen
  import interp_pass_sequencer_pkg::*;
(
  input  pass_mode_e        i_mode,
  input  logic [L_W-1:0]    i_line,
  input  logic [K_W-1:0]    i_samp,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_line;
  logic [ADDR_W-1:0] w_samp;

  assign w_line = ADDR_W'(i_line);
  assign w_samp = ADDR_W'(i_samp);

  // In COL mode a line is a column, so the sample index selects the row.
  assign o_addr = (i_mode == COL) ? (w_samp * ADDR_W'(WIDTH) + w_line)
                                  : (w_line * ADDR_W'(WIDTH) + w_samp);

endmodule

// File: rtl/interp_pass_sequencer.sv
// Drives one padded interpolation pass over the frame and writes results.
//
// state | meaning
// IDLE  | waiting for start; data_in holds last sample
// PRIME | first source read (line 0, feed 0) is on the bus
// FEED  | reads run one cycle ahead of memory data, two ahead of feed
// DONE  | one-cycle done pulse, then back to IDLE
module interp_pass_sequencer
  import interp_pass_sequencer_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_mode,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_interp_data_in,
  input  logic [31:0]       i_interp_a,
  input  logic [31:0]       i_interp_b,
  input  logic [31:0]       i_interp_c,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [OUT_W-1:0]  o_wr_a,
  output logic [OUT_W-1:0]  o_wr_b,
  output logic [OUT_W-1:0]  o_wr_c
);

  seq_state_e        r_state;
  pass_mode_e        r_mode;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_data_in;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [L_W-1:0]    r_rl;
  logic [K_W-1:0]    r_rk;
  logic [L_W-1:0]    r_fl;
  logic [K_W-1:0]    r_fk;
  logic              r_dvalid;
  logic              r_feed_last;

  logic [L_W-1:0]    w_nl;
  logic [K_W-1:0]    w_ns;
  logic [K_W-1:0]    w_ll_m1;
  logic [K_W-1:0]    w_rd_samp;
  logic [K_W-1:0]    w_wr_samp;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_rd_more;
  logic              w_rk_wrap;
  logic              w_fk_wrap;
  logic              w_f_last;
  logic              w_cap;
  logic              w_unused;

  assign w_nl      = (r_mode == COL) ? L_W'(WIDTH)  : L_W'(HEIGHT);
  assign w_ns      = (r_mode == COL) ? K_W'(HEIGHT) : K_W'(WIDTH);
  assign w_ll_m1   = w_ns + K_W'(PAD_LEAD + PAD_TRAIL - 1);
  assign w_rd_samp = src_index(r_rk, w_ns);
  assign w_rd_more = (r_rl != w_nl);
  assign w_rk_wrap = (r_rk == w_ll_m1);
  assign w_fk_wrap = (r_fk == w_ll_m1);
  assign w_f_last  = w_fk_wrap && (r_fl == w_nl - L_W'(1));
  assign w_cap     = (r_fk >= K_W'(CAP_OFS));
  assign w_wr_samp = w_cap ? (r_fk - K_W'(CAP_OFS)) : '0;

  interp_pass_sequencer_addr_gen u_rd_addr (
    .i_mode (r_mode),
    .i_line (r_rl),
    .i_samp (w_rd_samp),
    .o_addr (w_rd_addr)
  );

  interp_pass_sequencer_addr_gen u_wr_addr (
    .i_mode (r_mode),
    .i_line (r_fl),
    .i_samp (w_wr_samp),
    .o_addr (w_wr_addr)
  );

  // Sequencer FSM: read counters (rl,rk) lead, feed counters (fl,fk) follow the returned data.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_mode      <= ROW;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_data_in   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_rl        <= '0;
      r_rk        <= '0;
      r_fl        <= '0;
      r_fk        <= '0;
      r_dvalid    <= 1'b0;
      r_feed_last <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            // Element (0,0) is address 0 in either mode, so it can be issued
            // on the same edge that latches the mode.
            r_state     <= PRIME;
            r_mode      <= pass_mode_e'(i_mode);
            r_busy      <= 1'b1;
            r_rd_en     <= 1'b1;
            r_rd_addr   <= '0;
            r_rl        <= '0;
            r_rk        <= K_W'(1);
            r_fl        <= '0;
            r_fk        <= '0;
            r_dvalid    <= 1'b0;
            r_feed_last <= 1'b0;
          end
        end

        PRIME, FEED: begin
          r_state  <= FEED;
          r_dvalid <= r_rd_en;

          if (w_rd_more) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= w_rd_addr;
            if (w_rk_wrap) begin
              r_rk <= '0;
              r_rl <= r_rl + L_W'(1);
            end else begin
              r_rk <= r_rk + K_W'(1);
            end
          end else begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
          end

          if (r_dvalid) begin
            r_data_in   <= i_rd_data;
            r_wr_en     <= w_cap;
            r_wr_addr   <= w_cap ? w_wr_addr : '0;
            r_feed_last <= w_f_last;
            if (w_fk_wrap) begin
              r_fk <= '0;
              r_fl <= r_fl + L_W'(1);
            end else begin
              r_fk <= r_fk + K_W'(1);
            end
          end else begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_feed_last <= 1'b0;
          end

          if (r_feed_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_rd_en          = r_rd_en;
  assign o_rd_addr        = r_rd_addr;
  assign o_interp_data_in = r_data_in;
  assign o_wr_en          = r_wr_en;
  assign o_wr_addr        = r_wr_addr;

  // The interpolator outputs are live in the capture cycle, so the slices
  // pass straight through, gated to zero whenever nothing is being written.
  assign o_wr_a = r_wr_en ? i_interp_a[OUT_LSB+OUT_W-1:OUT_LSB] : '0;
  assign o_wr_b = r_wr_en ? i_interp_b[OUT_LSB+OUT_W-1:OUT_LSB] : '0;
  assign o_wr_c = r_wr_en ? i_interp_c[OUT_LSB+OUT_W-1:OUT_LSB] : '0;

  assign w_unused = ^{i_interp_a[31:OUT_LSB+OUT_W], i_interp_a[OUT_LSB-1:0],
                      i_interp_b[31:OUT_LSB+OUT_W], i_interp_b[OUT_LSB-1:0],
                      i_interp_c[31:OUT_LSB+OUT_W], i_interp_c[OUT_LSB-1:0]};

endmodule
